// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle sequencer for the 3-bit opcode path.
// Steps each opcode through DECODE, EXEC/MEM and WB with registered strobes.
module instr_sequencer #(
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [2:0]       opcode,
  output logic             instr_ready,
  input  logic             mem_ack,
  output logic [2:0]       alu_op,
  output logic             wen_reg,
  output logic             ren_mem,
  output logic             wen_mem,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err_timeout,
  output logic             halted
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_JMP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic is_mem(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       ir_q, ir_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  logic             ready_q, ready_d;
  logic [2:0]       alu_q, alu_d;
  logic             wreg_q, wreg_d;
  logic             rmem_q, rmem_d;
  logic             wmem_q, wmem_d;
  logic             pinc_q, pinc_d;
  logic             pload_q, pload_d;
  logic             ret_q, ret_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    abort_d = abort_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        abort_d = 1'b0;
        wait_d  = '0;
        unique case (1'b1)
          (ir_q == OP_NOP):                    state_d = S_WB;
          (is_alu(ir_q) || ir_q == OP_JMP):    state_d = S_EXEC;
          is_mem(ir_q):                        state_d = S_MEM;
          default:                             state_d = S_HALT;
        endcase
      end
      S_EXEC: state_d = S_WB;
      S_MEM: begin
        // a late ack still beats the timeout in the same cycle
        if (mem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WLAST) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_WB;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB:   state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // strobes are precomputed for the next state so they leave a flop
  always_comb begin
    alu_d   = 3'd0;
    wreg_d  = 1'b0;
    rmem_d  = 1'b0;
    wmem_d  = 1'b0;
    pinc_d  = 1'b0;
    pload_d = 1'b0;
    ret_d   = 1'b0;
    ready_d = (state_d == S_IDLE);
    halt_d  = (state_d == S_HALT);
    unique case (state_d)
      S_EXEC: begin
        if (is_alu(ir_d)) alu_d = ir_d;
        pload_d = (ir_d == OP_JMP);
      end
      S_MEM: begin
        rmem_d = (ir_d == OP_LOAD);
        wmem_d = (ir_d == OP_STORE);
      end
      S_WB: begin
        wreg_d = is_alu(ir_d) || (ir_d == OP_LOAD && !abort_d);
        pinc_d = (ir_d != OP_JMP);
        ret_d  = 1'b1;
      end
      default: ;
    endcase
    cnt_d = ret_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= 3'd0;
      wait_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      alu_q   <= 3'd0;
      wreg_q  <= 1'b0;
      rmem_q  <= 1'b0;
      wmem_q  <= 1'b0;
      pinc_q  <= 1'b0;
      pload_q <= 1'b0;
      ret_q   <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      rmem_q  <= rmem_d;
      wmem_q  <= wmem_d;
      pinc_q  <= pinc_d;
      pload_q <= pload_d;
      ret_q   <= ret_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready = ready_q & ~rst;
  assign alu_op      = alu_q;
  assign wen_reg     = wreg_q;
  assign ren_mem     = rmem_q;
  assign wen_mem     = wmem_q;
  assign pc_inc      = pinc_q;
  assign pc_load     = pload_q;
  assign retire      = ret_q;
  assign retire_cnt  = cnt_q;
  assign err_timeout = err_q;
  assign halted      = halt_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer for the 3-bit opcode instruction path. It accepts one opcode at a time over a valid/ready handshake and steps it through DECODE, EXEC/MEM and WB phases. In each phase it drives the ALU select, register-file write enable and memory read/write strobes. It sits between the instruction source and the datapath/memory, and replaces single-cycle decoding with a sequenced, memory-wait-tolerant flow.

## Interface
- CNT_W, 8, width of retired-instruction counter
- MEM_TIMEOUT, 15, max MEM-state cycles waiting for mem_ack (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  opcode valid
- opcode  input  3  instruction opcode
- instr_ready  output  1  sequencer can accept an opcode
- mem_ack  input  1  memory completed current access
- alu_op  output  3  ALU function select
- wen_reg  output  1  register-file write enable
- ren_mem  output  1  memory read strobe
- wen_mem  output  1  memory write strobe
- pc_inc  output  1  advance PC by one
- pc_load  output  1  load PC with jump target
- retire  output  1  one-cycle pulse per completed instruction
- retire_cnt  output  CNT_W  retired-instruction count, wraps
- err_timeout  output  1  sticky: a memory access timed out
- halted  output  1  HALT executed

## Operation
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 LOAD, 101 STORE, 110 JMP, 111 HALT.
- States: IDLE, DECODE, EXEC, MEM, WB, HALT.
- IDLE
  - instr_ready=1, gated low while rst=1.
  - On instr_valid&instr_ready at a clock edge: opcode is latched into internal ir and the state goes to DECODE.
  - opcode is ignored at all other times.
- DECODE: all strobes 0. Next state:
  - NOP→WB
  - ADD/SUB/AND/JMP→EXEC
  - LOAD/STORE→MEM
  - HALT→HALT
- EXEC
  - ALU ops: alu_op=ir.
  - JMP: pc_load=1, alu_op=000.
  - Next state WB.
- MEM
  - ren_mem=1 (LOAD) or wen_mem=1 (STORE), held every MEM cycle.
  - A wait counter is cleared on MEM entry.
  - mem_ack=1 → WB (success).
  - If MEM_TIMEOUT MEM cycles elapse with no ack → err_timeout set, WB with abort flag.
  - If ack and timeout fall in the same cycle, ack wins.
- WB
  - wen_reg=1 for ADD/SUB/AND, and for LOAD if not aborted.
  - pc_inc=1 for all opcodes except JMP.
  - retire=1; retire_cnt increments, wrapping 2^CNT_W−1→0.
  - Next state IDLE.
- HALT: halted=1, instr_ready=0, all strobes 0. The only exit is rst. HALT does not retire.
- All outputs are decoded from registered state and ir only; none depends combinationally on inputs, except the rst gating of instr_ready.
- err_timeout is sticky until rst. Aborted STORE still retires with pc_inc=1.
- mem_ack outside MEM is ignored.

## Timing
- Reset state: IDLE.
- Reset values, applied immediately and asynchronously:
  - alu_op=000; wen_reg=ren_mem=wen_mem=pc_inc=pc_load=retire=0
  - retire_cnt=0, err_timeout=0, halted=0, instr_ready=0
- instr_ready=1 in the first cycle after rst deasserts.
- Reset mid-instruction aborts it with no WB and no retire.
- Handshake at edge T0:
  - ALU op / JMP: DECODE T0–T1, EXEC T1–T2, WB T2–T3, ready again after T3. Latency 4 cycles.
  - NOP: WB in T1–T2, ready after T2. Latency 3 cycles.
  - LOAD/STORE with ack in the k-th MEM cycle: WB in cycle k+2, total 3+k cycles.
  - Timeout: WB after MEM_TIMEOUT MEM cycles.
- Back-to-back: a new handshake occurs at the first edge in IDLE. There are no bubbles beyond the latency above.
- Bench drives inputs on the negedge, so sampling at the posedge is race-free.

## Test plan
- Reset for 3 cycles, then ADD (001) with valid one cycle → alu_op=001 in EXEC, wen_reg=1 and retire=1 in WB 3 cycles after accept, retire_cnt=1, instr_ready back high on the 4th cycle.
- LOAD (100) with mem_ack raised in the 3rd MEM cycle → ren_mem high for exactly 3 cycles, then wen_reg=1 and pc_inc=1 in WB. STORE (101) with ack in the 1st MEM cycle → wen_mem high for 1 cycle, wen_reg=0.
- LOAD with no ack, MEM_TIMEOUT=15 → ren_mem high for 15 cycles, err_timeout=1 and stays set, WB has wen_reg=0 and retire=1. Next NOP completes normally.
- JMP (110) → pc_load=1 in EXEC, pc_inc=0 in WB. HALT (111) → halted=1, instr_ready=0, no retire; later opcodes ignored until rst.
- Stream of 257 NOPs with valid held high (CNT_W=8) → one retire every 3 cycles, retire_cnt wraps 255→0→1.
- Assert rst during MEM of a STORE → wen_mem=0 immediately, no retire, retire_cnt=0, err_timeout=0. Sequencer accepts a new opcode the cycle after rst falls.
